// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg -- shared definitions for the external-memory front-end arbiter.
//
// Contents:
//   arb_state_t : arbiter FSM encoding (IDLE=0, BUSY=1, INV_WAIT=2, INV=3)
//   req_w()     : width of one flattened request {valid, addr, wdata, wstrb}
//   resp_w()    : width of one flattened response {ready, rdata}
//   *_off()     : bit offsets of master i inside the flattened per-master buses
//   ptr_w()     : width of a master index (at least 1 bit, also for one master)
package ext_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_INV_WAIT = 2'd2,
    ST_INV      = 2'd3
  } arb_state_t;

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return 1 + data_w;
  endfunction

  function automatic int addr_off(input int idx, input int addr_w);
    return idx * addr_w;
  endfunction

  function automatic int data_off(input int idx, input int data_w);
    return idx * data_w;
  endfunction

  function automatic int strb_off(input int idx, input int data_w);
    return idx * (data_w / 8);
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_mem_rr_sel.sv
// ext_mem_rr_sel -- combinational rotate-priority picker.
//
// Returns the index of the first set bit of i_req, searching upward from
// i_ptr and wrapping modulo N_MASTERS. o_any flags that some bit is set;
// o_idx is 0 when nothing is requested.
//
// Ports:
//   i_req [N_MASTERS-1:0] request vector
//   i_ptr [PTR_W-1:0]     search start (always < N_MASTERS)
//   o_idx [PTR_W-1:0]     selected master index
//   o_any                 at least one request present
module ext_mem_rr_sel
  import ext_mem_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [PTR_W-1:0]     o_idx,
  output logic                 o_any
);

  logic w_found;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % N_MASTERS]) begin
        o_idx   = PTR_W'((int'(i_ptr) + k) % N_MASTERS);
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/ext_mem_arb.sv
// ext_mem_arb -- N-master round-robin arbiter onto the L2 front-end port,
// with sequenced L2 invalidation.
//
// The grant is registered in IDLE and held for the whole transaction; the
// L2 request fields are a combinational pass-through of the granted master
// while BUSY and zero otherwise. A completion returns to IDLE, so back-to-back
// requests see one bubble cycle. An invalidate request is remembered in
// inv_pending and issued from IDLE only, so it can never overlap an L2 access.
//
// Build option:
//   EXT_MEM_ARB_WTB_WAIT_EN defined   : INV_WAIT holds until i_wtb_empty=1
//   EXT_MEM_ARB_WTB_WAIT_EN undefined : INV_WAIT lasts one cycle, i_wtb_empty unused
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_m_valid/addr/wdata/wstrb per-master request (flattened, master i at i*W)
//   o_m_rdata                 read data broadcast (= i_s_rdata)
//   o_m_ready                 one-cycle completion pulse to the granted master
//   o_s_valid/addr/wdata/wstrb L2 request
//   i_s_rdata, i_s_ready      L2 response
//   i_inv_req                 invalidate request pulse
//   i_wtb_empty               L2 write-through buffer empty
//   o_s_inv                   one-cycle invalidate to L2
//   o_inv_pending             invalidate requested but not yet issued
//
// State | meaning
// IDLE     | no transaction; arbitrate or start a pending invalidate
// BUSY     | granted master drives L2, waiting for i_s_ready
// INV_WAIT | invalidate queued, waiting for write-through drain
// INV      | o_s_inv asserted for this single cycle
module ext_mem_arb
  import ext_mem_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [N_MASTERS-1:0]            i_m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     i_m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     i_m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   i_m_wstrb,
  output logic [DATA_W-1:0]               o_m_rdata,
  output logic [N_MASTERS-1:0]            o_m_ready,
  output logic                            o_s_valid,
  output logic [ADDR_W-1:0]               o_s_addr,
  output logic [DATA_W-1:0]               o_s_wdata,
  output logic [DATA_W/8-1:0]             o_s_wstrb,
  input  logic [DATA_W-1:0]               i_s_rdata,
  input  logic                            i_s_ready,
  input  logic                            i_inv_req,
  input  logic                            i_wtb_empty,
  output logic                            o_s_inv,
  output logic                            o_inv_pending
);

  localparam int PTR_W  = ptr_w(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [PTR_W-1:0]  r_grant;
  logic [PTR_W-1:0]  w_grant_nxt;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  w_rr_ptr_nxt;
  logic              r_inv_pending;
  logic              w_inv_pending_nxt;
  logic [PTR_W-1:0]  w_sel_idx;
  logic              w_any_req;
  logic [PTR_W-1:0]  w_grant_inc;
  logic              w_gnt_valid;
  logic [REQ_W-1:0]  w_gnt_req;

`ifndef EXT_MEM_ARB_WTB_WAIT_EN
  logic w_unused_wtb;
  assign w_unused_wtb = i_wtb_empty;
`endif

  ext_mem_rr_sel #(
    .N_MASTERS (N_MASTERS),
    .PTR_W     (PTR_W)
  ) u_rr_sel (
    .i_req (i_m_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_sel_idx),
    .o_any (w_any_req)
  );

  // Granted master's request, flattened as {valid, addr, wdata, wstrb}.
  assign w_gnt_valid = i_m_valid[r_grant];
  assign w_gnt_req   = {w_gnt_valid,
                        i_m_addr [addr_off(int'(r_grant), ADDR_W) +: ADDR_W],
                        i_m_wdata[data_off(int'(r_grant), DATA_W) +: DATA_W],
                        i_m_wstrb[strb_off(int'(r_grant), DATA_W) +: STRB_W]};

  // grant+1 modulo N; collapses to 0 for a single master.
  assign w_grant_inc = (r_grant == PTR_W'(N_MASTERS - 1)) ? '0 : r_grant + PTR_W'(1);

  assign o_m_rdata     = i_s_rdata;
  assign o_inv_pending = r_inv_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_inv_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_inv_pending <= w_inv_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_inv_pending_nxt = r_inv_pending | i_inv_req;
    o_s_valid         = 1'b0;
    o_s_addr          = '0;
    o_s_wdata         = '0;
    o_s_wstrb         = '0;
    o_m_ready         = '0;
    o_s_inv           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Pending invalidate wins over new requests.
        if (r_inv_pending) begin
          w_state_nxt = ST_INV_WAIT;
        end else if (w_any_req) begin
          w_grant_nxt = w_sel_idx;
          w_state_nxt = ST_BUSY;
        end
      end

      ST_BUSY: begin
        {o_s_valid, o_s_addr, o_s_wdata, o_s_wstrb} = w_gnt_req;
        if (!w_gnt_valid) begin
          // Master withdrew before completion: abandon without rotating.
          w_state_nxt = ST_IDLE;
        end else if (i_s_ready) begin
          o_m_ready[r_grant] = 1'b1;
          w_rr_ptr_nxt       = w_grant_inc;
          w_state_nxt        = ST_IDLE;
        end
      end

      ST_INV_WAIT: begin
`ifdef EXT_MEM_ARB_WTB_WAIT_EN
        if (i_wtb_empty) begin
          w_state_nxt = ST_INV;
        end
`else
        w_state_nxt = ST_INV;
`endif
      end

      ST_INV: begin
        o_s_inv = 1'b1;
        // A request landing in this very cycle queues another invalidate.
        w_inv_pending_nxt = i_inv_req;
        w_state_nxt       = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ext_mem_arb.sv
// Self-checking bench for ext_mem_arb: 4 masters, 32-bit address, 64-bit data.
module tb_ext_mem_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            inv_req;
  logic            wtb_empty;
  logic            s_inv;
  logic            inv_pending;

  logic [AW-1:0]   mdl_addr  [N];
  logic [DW-1:0]   mdl_wdata [N];
  logic [SW-1:0]   mdl_wstrb [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_mem_arb #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_m_valid     (m_valid),
    .i_m_addr      (m_addr),
    .i_m_wdata     (m_wdata),
    .i_m_wstrb     (m_wstrb),
    .o_m_rdata     (m_rdata),
    .o_m_ready     (m_ready),
    .o_s_valid     (s_valid),
    .o_s_addr      (s_addr),
    .o_s_wdata     (s_wdata),
    .o_s_wstrb     (s_wstrb),
    .i_s_rdata     (s_rdata),
    .i_s_ready     (s_ready),
    .i_inv_req     (inv_req),
    .i_wtb_empty   (wtb_empty),
    .o_s_inv       (s_inv),
    .o_inv_pending (inv_pending)
  );

  task automatic set_master(input int i, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_addr [i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW] = s;
    mdl_addr[i]  = a;
    mdl_wdata[i] = d;
    mdl_wstrb[i] = s;
  endtask

  // Ends on a negedge with reset just released; state is IDLE with ptr 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; m_valid = '0; s_ready = 1'b0; inv_req = 1'b0; wtb_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    m_valid = '1; s_ready = 1'b1; inv_req = 1'b1; wtb_empty = 1'b1;
    s_rdata = '0;
    for (int i = 0; i < N; i++) set_master(i, $urandom, {$urandom, $urandom}, 8'hff);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({s_valid, s_inv, inv_pending, m_ready} !== 7'b0)
      begin n_err++; $display("FAIL reset_ctrl: got %b want 0000000", {s_valid, s_inv, inv_pending, m_ready}); end
    n_cmp++;
    if ({s_addr, s_wdata, s_wstrb} !== '0)
      begin n_err++; $display("FAIL reset_bus: got %h want 0", {s_addr, s_wdata, s_wstrb}); end
    m_valid = '0; s_ready = 1'b0; inv_req = 1'b0;
  endtask

  task automatic test_rr();
    logic [N-1:0] exp_rdy;
    do_reset();
    set_master(0, 32'h0000_0100, {$urandom, $urandom}, 8'h00);
    set_master(1, 32'h0000_0200, {$urandom, $urandom}, 8'hf0);
    m_valid = 4'b0011;
    #1;
    n_cmp++;
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL rr_first_idle: s_valid %b want 0", s_valid); end
    for (int t = 0; t < 4; t++) begin
      int em;
      em = t % 2;
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        s_ready = (b == 2);
        s_rdata = {$urandom, $urandom};
        #1;
        n_cmp++;
        if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, mdl_addr[em], mdl_wdata[em], mdl_wstrb[em]})
          begin n_err++; $display("FAIL rr_grant t%0d: got v%b a%h want master %0d a%h", t, s_valid, s_addr, em, mdl_addr[em]); end
        exp_rdy = (b == 2) ? (4'b0001 << em) : 4'b0000;
        n_cmp++;
        if (m_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready t%0d: got %b want %b", t, m_ready, exp_rdy); end
      end
      @(negedge clk);
      s_ready = 1'b0;
      if (t == 3) m_valid = '0;
      #1;
      n_cmp++;
      if ({s_valid, m_ready} !== 5'b0) begin n_err++; $display("FAIL rr_bubble t%0d: got %b want 00000", t, {s_valid, m_ready}); end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] aa;
    aa = {SW{8'hAA}};
    @(negedge clk);
    set_master(2, 32'h0000_1000, {$urandom, $urandom}, 8'h00);
    m_valid = 4'b0100;
    #1;
    n_cmp++;
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: s_valid %b want 0", s_valid); end
    @(negedge clk);
    s_ready = 1'b1; s_rdata = aa;
    #1;
    n_cmp++;
    if ({s_valid, s_addr, s_wstrb} !== {1'b1, 32'h0000_1000, 8'h00})
      begin n_err++; $display("FAIL single_req: got v%b a%h s%h want v1 a00001000 s00", s_valid, s_addr, s_wstrb); end
    n_cmp++;
    if ({m_ready, m_rdata} !== {4'b0100, aa})
      begin n_err++; $display("FAIL single_resp: got %b %h want 0100 %h", m_ready, m_rdata, aa); end
    @(negedge clk);
    s_ready = 1'b0; m_valid = '0;
    #1;
    n_cmp++;
    if ({s_valid, m_ready} !== 5'b0) begin n_err++; $display("FAIL single_after: got %b want 00000", {s_valid, m_ready}); end
  endtask

  task automatic test_inv_busy();
    logic          e_sv, e_inv, e_pend;
    logic [N-1:0]  e_rdy;
    logic [AW-1:0] e_addr;
    set_master(0, 32'h0000_A000, {$urandom, $urandom}, 8'h0f);
    set_master(1, 32'h0000_B000, {$urandom, $urandom}, 8'h00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      m_valid = (c == 0) ? 4'b0001 : (c <= 3) ? 4'b0011 : (c <= 8) ? 4'b0010 : 4'b0000;
      inv_req = (c == 1);
      s_ready = (c == 3) || (c == 8);
      #1;
      e_sv   = (c >= 1 && c <= 3) || (c == 8);
      e_inv  = (c == 6);
      e_pend = (c >= 2 && c <= 6);
      e_rdy  = (c == 3) ? 4'b0001 : (c == 8) ? 4'b0010 : 4'b0000;
      e_addr = !e_sv ? '0 : (c <= 3) ? mdl_addr[0] : mdl_addr[1];
      n_cmp++;
      if ({s_valid, s_inv, inv_pending, m_ready, s_addr} !== {e_sv, e_inv, e_pend, e_rdy, e_addr})
        begin n_err++; $display("FAIL inv_busy c%0d: got v%b i%b p%b r%b a%h want v%b i%b p%b r%b a%h",
          c, s_valid, s_inv, inv_pending, m_ready, s_addr, e_sv, e_inv, e_pend, e_rdy, e_addr); end
    end
    inv_req = 1'b0; s_ready = 1'b0;
  endtask

  task automatic test_double_inv();
    logic e_inv, e_pend;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      inv_req = (c == 0) || (c == 3);
      #1;
      e_inv  = (c == 3) || (c == 6);
      e_pend = (c >= 1 && c <= 6);
      n_cmp++;
      if ({s_valid, s_inv, inv_pending} !== {1'b0, e_inv, e_pend})
        begin n_err++; $display("FAIL double_inv c%0d: got v%b i%b p%b want v0 i%b p%b", c, s_valid, s_inv, inv_pending, e_inv, e_pend); end
    end
    inv_req = 1'b0;
  endtask

  task automatic test_wtb();
    int e_cyc;
    logic e_sv, e_inv, e_pend;
`ifdef EXT_MEM_ARB_WTB_WAIT_EN
    e_cyc = 12;
`else
    e_cyc = 3;
`endif
    set_master(3, 32'h0000_3000, {$urandom, $urandom}, 8'h81);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      wtb_empty = (c >= 11);
      inv_req   = (c == 0);
      m_valid   = (c >= 1) ? 4'b1000 : 4'b0000;
      #1;
      e_inv  = (c == e_cyc);
      e_pend = (c >= 1) && (c <= e_cyc);
      e_sv   = (c >= e_cyc + 2);
      n_cmp++;
      if ({s_valid, s_inv, inv_pending} !== {e_sv, e_inv, e_pend})
        begin n_err++; $display("FAIL wtb c%0d: got v%b i%b p%b want v%b i%b p%b", c, s_valid, s_inv, inv_pending, e_sv, e_inv, e_pend); end
    end
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    n_cmp++;
    if ({m_ready, s_addr} !== {4'b1000, mdl_addr[3]})
      begin n_err++; $display("FAIL wtb_done: got r%b a%h want r1000 a%h", m_ready, s_addr, mdl_addr[3]); end
    @(negedge clk);
    s_ready = 1'b0; m_valid = '0; wtb_empty = 1'b1;
    #1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_master(1, 32'h0000_1111, {$urandom, $urandom}, 8'h00);
    m_valid = 4'b0010;
    #1;
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    n_cmp++;
    if (m_ready !== 4'b0010) begin n_err++; $display("FAIL ar_pre: m_ready %b want 0010", m_ready); end
    @(negedge clk);
    s_ready = 1'b0; m_valid = 4'b0001;
    set_master(0, 32'h0000_0000, {$urandom, $urandom}, 8'h3c);
    set_master(2, 32'h0000_2222, {$urandom, $urandom}, 8'h00);
    #1;
    @(negedge clk);
    inv_req = 1'b1;
    #1;
    @(negedge clk);
    inv_req = 1'b0; s_ready = 1'b1;
    #1;
    n_cmp++;
    if ({s_valid, m_ready, inv_pending} !== {1'b1, 4'b0001, 1'b1})
      begin n_err++; $display("FAIL ar_busy: got v%b r%b p%b want v1 r0001 p1", s_valid, m_ready, inv_pending); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s_valid, m_ready, inv_pending, s_inv, s_addr} !== '0)
      begin n_err++; $display("FAIL ar_async: got v%b r%b p%b i%b a%h want all 0", s_valid, m_ready, inv_pending, s_inv, s_addr); end
    @(negedge clk);
    s_ready = 1'b0; m_valid = 4'b0111; rst_n = 1'b1;
    #1;
    n_cmp++;
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL ar_idle: s_valid %b want 0", s_valid); end
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    n_cmp++;
    if ({s_valid, s_addr, m_ready} !== {1'b1, mdl_addr[0], 4'b0001})
      begin n_err++; $display("FAIL ar_first_grant: got v%b a%h r%b want v1 a%h r0001", s_valid, s_addr, m_ready, mdl_addr[0]); end
    @(negedge clk);
    s_ready = 1'b0; m_valid = '0;
    #1;
  endtask

  task automatic test_random();
    int owner, ptr, lat_tgt, lat_cnt;
    bit l2_busy;
    int gap [N];
    logic [N-1:0] done;
    logic [N-1:0] e_rdy;
    logic [AW+DW+SW:0] e_bus;
    do_reset();
    owner = -1; ptr = 0; lat_tgt = 0; lat_cnt = 0; l2_busy = 0; done = '0;
    for (int i = 0; i < N; i++) gap[i] = $urandom_range(0, 2);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          gap[i] = $urandom_range(0, 3);
          if (gap[i] == 0)
            set_master(i, $urandom, {$urandom, $urandom}, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
          else
            m_valid[i] = 1'b0;
        end else if (!m_valid[i]) begin
          if (gap[i] == 0) begin
            set_master(i, $urandom, {$urandom, $urandom}, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
            m_valid[i] = 1'b1;
          end else begin
            gap[i]--;
          end
        end
      end
      s_rdata = {$urandom, $urandom};
      #1;
      if (s_valid) begin
        if (!l2_busy) begin l2_busy = 1; lat_tgt = $urandom_range(0, 3); lat_cnt = 0; end
        s_ready = (lat_cnt == lat_tgt);
        lat_cnt++;
        if (s_ready) l2_busy = 0;
      end else begin
        s_ready = 1'b0; l2_busy = 0;
      end
      #1;
      if (owner >= 0) begin
        e_bus = {1'b1, mdl_addr[owner], mdl_wdata[owner], mdl_wstrb[owner]};
        e_rdy = s_ready ? (4'b0001 << owner) : 4'b0000;
      end else begin
        e_bus = '0;
        e_rdy = '0;
      end
      n_cmp++;
      if ({s_valid, s_addr, s_wdata, s_wstrb} !== e_bus)
        begin n_err++; $display("FAIL rand_bus cyc%0d: got %h want %h (owner %0d)", cyc, {s_valid, s_addr, s_wdata, s_wstrb}, e_bus, owner); end
      n_cmp++;
      if ({m_ready, s_inv, m_rdata} !== {e_rdy, 1'b0, s_rdata})
        begin n_err++; $display("FAIL rand_resp cyc%0d: got r%b i%b d%h want r%b i0 d%h", cyc, m_ready, s_inv, m_rdata, e_rdy, s_rdata); end
      done = '0;
      if (owner >= 0) begin
        if (s_ready) begin
          done[owner] = 1'b1;
          ptr = (owner + 1) % N;
          owner = -1;
        end
      end else if (m_valid != '0) begin
        owner = pick(ptr, m_valid);
      end
    end
    @(negedge clk);
    m_valid = '0; s_ready = 1'b0;
  endtask

  initial begin
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
    test_reset();
    test_rr();
    test_single();
    test_inv_busy();
    test_double_inv();
    test_wtb();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ext_mem_arb.md
Name: ext_mem_arb

Overview:
- Parametrised N-master native-bus arbiter that merges cache back-end buses into one L2 front-end port of the external-memory subsystem.
- Replaces the fixed 1/2-master merge plus ad-hoc invalidate register.
- Round-robin arbitration with a registered grant, held for the whole transaction.
- Sequences L2 invalidation so it is never issued while an L2 access is in flight.

Parameters:
- N_MASTERS, 2, number of requesting masters (1..8).
- ADDR_W, 32, byte-address width on both sides (DCACHE_ADDR_W).
- DATA_W, 256, data bus width (MIG_BUS_W); multiple of 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- m_valid  in  N_MASTERS  per-master request valid.
- m_addr  in  N_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; all zero means read.
- m_rdata  out  DATA_W  read data, broadcast to all masters.
- m_ready  out  N_MASTERS  per-master completion pulse.
- s_valid  out  1  L2 request valid.
- s_addr  out  ADDR_W  L2 address.
- s_wdata  out  DATA_W  L2 write data.
- s_wstrb  out  DATA_W/8  L2 byte strobes.
- s_rdata  in  DATA_W  L2 read data.
- s_ready  in  1  L2 completion.
- inv_req  in  1  invalidate request pulse (dcache force_inv_out).
- wtb_empty  in  1  L2 write-through buffer empty.
- s_inv  out  1  one-cycle force-invalidate to L2.
- inv_pending  out  1  invalidate requested but not yet issued.

Behaviour:
- Reset (rst low, async): state IDLE, grant 0, rr_ptr 0, inv_pending 0; s_valid, s_inv and m_ready all 0; s_addr, s_wdata, s_wstrb 0.
- States: IDLE, BUSY, INV_WAIT, INV.
- inv_pending is sticky:
  - set on any cycle with inv_req=1;
  - cleared only in the INV cycle;
  - if inv_req=1 in the INV cycle, it stays set, so a second invalidate follows.
- IDLE:
  - If inv_pending=1, go to INV_WAIT; invalidate has priority over new requests.
  - Else if any m_valid, pick the first set bit searching from rr_ptr upward, modulo N_MASTERS. Register it as grant and go to BUSY.
  - Else stay in IDLE.
- BUSY:
  - s_valid, s_addr, s_wdata and s_wstrb come combinationally from the granted master; all are zero outside BUSY.
  - On s_ready=1: m_ready[grant]=1 for that same cycle, m_rdata=s_rdata, rr_ptr=grant+1 modulo N, then go to IDLE.
  - If m_valid[grant] drops before s_ready (protocol violation): go to IDLE, no m_ready, rr_ptr unchanged.
- m_rdata is always driven by s_rdata. m_ready for non-granted masters is always 0.
- Latency: a request seen in IDLE reaches s_valid the next cycle. Minimum 2 cycles from m_valid to m_ready when L2 answers in 1 cycle.
- Back-to-back: after a completion there is 1 IDLE bubble cycle before the next grant.
- N_MASTERS=1: rr_ptr is held at 0; arbitration degenerates to pass-through plus 1 cycle.
- Invalidate never coincides with s_valid=1 by construction.
- INV_WAIT goes to INV (see Optional Feature).
- INV: s_inv=1 for exactly one cycle, clear inv_pending, then go to IDLE.

Optional Feature:
- Macro: EXT_MEM_ARB_WTB_WAIT_EN.
- Defined: INV_WAIT stays until wtb_empty=1, then goes to INV, so pending L2 writes drain before the invalidate. Requests keep waiting during this time.
- Undefined: INV_WAIT goes to INV unconditionally after 1 cycle; the wtb_empty port is present but unused.

Decomposition:
- Shared package ext_mem_pkg holds:
  - state encoding (IDLE=0, BUSY=1, INV_WAIT=2, INV=3);
  - REQ_W/RESP_W width constants;
  - field-offset constants for the flattened buses.
- Sub-module ext_mem_rr_sel: purely combinational rotate-priority picker. Inputs are the request vector and rr_ptr; outputs are grant index and any_req.
- The FSM and registers stay in ext_mem_arb.

Test Plan:
- N=2, m_valid=11 from reset, L2 ready after 3 cycles each → grant order 0,1,0,1; each m_ready pulses once; s_valid low for the 1 bubble cycle between grants.
- N=4, only master 2 requests, addr 0x1000, wstrb=0, s_rdata=0xAA..AA → s_addr=0x1000 the next cycle; m_ready[2] with m_rdata=0xAA..AA; no other m_ready bit set.
- inv_req pulses while master 0 is in BUSY awaiting ready → s_inv stays 0 until ready plus IDLE. Then s_inv is high exactly 1 cycle, before master 1's queued request is granted.
- EXT_MEM_ARB_WTB_WAIT_EN defined, wtb_empty=0 for 10 cycles after inv_req → s_inv fires on the cycle after wtb_empty rises; inv_pending stays 1 until then.
- rst driven low mid-BUSY → s_valid, m_ready and inv_pending drop to 0 immediately (asynchronous). After release, the first grant goes to master 0.
- inv_req pulses in the INV cycle itself → two s_inv pulses separated by an IDLE and an INV_WAIT cycle.
